// File: rtl/pipeline_controller.sv
// Hazard/flush sequencer for the 5-stage core: per-stage stall and flush
// controls, misprediction recovery, stall/flush counters and busy timeout.
module pipeline_controller #(
   parameter int unsigned FLUSH_CYCLES   = 2,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        decode_hazard_i,
   input  logic        ex_busy_i,
   input  logic        mem_busy_i,
   input  logic        branch_mispredict_i,
   output logic        stall_fetch_o,
   output logic        stall_decode_o,
   output logic        stall_execute_o,
   output logic        stall_memory_o,
   output logic        flush_fetch_o,
   output logic        flush_decode_o,
   output logic        flush_execute_o,
   output logic [31:0] stall_cycles_o,
   output logic [31:0] flush_count_o,
   output logic        timeout_o
);

   typedef enum logic [1:0] {RUN, MEM_WAIT, EX_WAIT, FLUSH} state_t;

   localparam logic [3:0]  FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);
   localparam logic [15:0] TO_LAST    = 16'(TIMEOUT_CYCLES - 1);
   // A single-cycle flush is fully covered by the redirect cycle itself.
   localparam state_t      REDIR_NEXT = (FLUSH_CYCLES > 1) ? FLUSH : RUN;

   state_t      state, state_n;
   logic [3:0]  cnt, cnt_n;
   logic        pend, pend_n;
   logic        redirect;
   logic [15:0] run_cnt;
   logic        busy;
   logic        sf, sd, se, sm, ff, fd, fe;

   assign busy = mem_busy_i | ex_busy_i;

   always_comb begin
      state_n  = state;
      cnt_n    = cnt;
      pend_n   = pend;
      redirect = 1'b0;
      sf = 1'b0; sd = 1'b0; se = 1'b0; sm = 1'b0;
      ff = 1'b0; fd = 1'b0; fe = 1'b0;
      if (busy) begin
         sf = 1'b1; sd = 1'b1; se = 1'b1;
         sm = mem_busy_i;
         state_n = mem_busy_i ? MEM_WAIT : EX_WAIT;
         // An interrupted flush is replayed in full once the busy clears.
         if (branch_mispredict_i || state == FLUSH)
            pend_n = 1'b1;
      end else if (branch_mispredict_i || pend) begin
         ff       = 1'b1;
         fd       = 1'b1;
         redirect = 1'b1;
         pend_n   = 1'b0;
         cnt_n    = FLUSH_LOAD;
         state_n  = REDIR_NEXT;
      end else if (state == FLUSH) begin
         fd      = 1'b1;
         cnt_n   = (cnt != 4'd0) ? cnt - 4'd1 : 4'd0;
         state_n = (cnt <= 4'd1) ? RUN : FLUSH;
      end else begin
         sf      = decode_hazard_i;
         state_n = RUN;
      end
   end

   assign stall_fetch_o   = rst_i & sf;
   assign stall_decode_o  = rst_i & sd;
   assign stall_execute_o = rst_i & se;
   assign stall_memory_o  = rst_i & sm;
   assign flush_fetch_o   = rst_i & ff;
   assign flush_decode_o  = rst_i & fd;
   assign flush_execute_o = rst_i & fe;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state          <= RUN;
         cnt            <= 4'd0;
         pend           <= 1'b0;
         stall_cycles_o <= 32'd0;
         flush_count_o  <= 32'd0;
         run_cnt        <= 16'd0;
         timeout_o      <= 1'b0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         pend  <= pend_n;
         if (stall_fetch_o)
            stall_cycles_o <= stall_cycles_o + 32'd1;
         if (redirect)
            flush_count_o <= flush_count_o + 32'd1;
         if (busy) begin
            if (run_cnt != 16'hFFFF)
               run_cnt <= run_cnt + 16'd1;
            if (run_cnt >= TO_LAST)
               timeout_o <= 1'b1;
         end else begin
            run_cnt <= 16'd0;
         end
      end
   end

endmodule
